// File: rtl/fnv1a_hash_if.sv
// Byte-stream in / hash-result out handshake bundle for the FNV hash core.
// master drives in_valid/in_data/in_last/out_ready; slave drives in_ready/out_*.
interface fnv1a_hash_if #(
    parameter int OUT_W = 32,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic [7:0]       in_data;
    logic             in_last;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_hash;
    logic [CNT_W-1:0] out_count;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_hash, out_count
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_hash, out_count
    );
endinterface

// File: rtl/fnv1a_hash_core.sv
// Streaming FNV-1 / FNV-1a hash core, one byte per cycle, optional XOR-fold.
// Ports: clk, rst (sync, active-high), mode, abort, busy, bus (slave handshake).
module fnv1a_hash_core #(
    parameter int HASH_W = 32,
    parameter int OUT_W  = HASH_W,
    parameter int CNT_W  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mode,
    input  logic        abort,
    output logic        busy,
    fnv1a_hash_if.slave bus
);
    localparam logic [63:0] OFFSET_64 = 64'hCBF2_9CE4_8422_2325;
    localparam logic [63:0] PRIME_64  = 64'h0000_0100_0000_01B3;
    localparam logic [63:0] OFFSET_32 = 64'h0000_0000_811C_9DC5;
    localparam logic [63:0] PRIME_32  = 64'h0000_0000_0100_0193;

    localparam logic [HASH_W-1:0] OFFSET =
        HASH_W'((HASH_W == 64) ? OFFSET_64 : OFFSET_32);
    localparam logic [HASH_W-1:0] PRIME =
        HASH_W'((HASH_W == 64) ? PRIME_64 : PRIME_32);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {IDLE, HASH, DONE} state_t;

    state_t            state;
    logic [HASH_W-1:0] h;
    logic [HASH_W-1:0] seed;
    logic [HASH_W-1:0] byte_ext;
    logic [HASH_W-1:0] h_next;
    logic [CNT_W-1:0]  cnt;
    logic              mode_q;
    logic              mode_eff;
    logic              accept;
    logic [OUT_W-1:0]  folded;

    // in_ready depends only on state, never on in_valid
    assign bus.in_ready = (state != DONE);
    assign accept       = bus.in_valid && bus.in_ready;

    // The first byte of a message starts from the offset basis and uses
    // the live mode input; later bytes use the running hash and latched mode.
    always_comb begin
        seed     = (state == IDLE) ? OFFSET : h;
        mode_eff = (state == IDLE) ? mode : mode_q;
        byte_ext = {{(HASH_W-8){1'b0}}, bus.in_data};
        if (mode_eff)
            h_next = (seed * PRIME) ^ byte_ext;
        else
            h_next = (seed ^ byte_ext) * PRIME;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            h      <= '0;
            cnt    <= '0;
            mode_q <= 1'b0;
        end else if (abort) begin
            state <= IDLE;
            h     <= '0;
            cnt   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        h      <= h_next;
                        cnt    <= CNT_W'(1);
                        mode_q <= mode;
                        state  <= bus.in_last ? DONE : HASH;
                    end
                end
                HASH: begin
                    if (accept) begin
                        h <= h_next;
                        if (cnt != CNT_MAX)
                            cnt <= cnt + CNT_W'(1);
                        state <= bus.in_last ? DONE : HASH;
                    end
                end
                DONE: begin
                    if (bus.out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    generate
        if (OUT_W == HASH_W) begin : g_full
            assign folded = h;
        end else begin : g_fold
            assign folded = h[HASH_W-1:OUT_W] ^ h[OUT_W-1:0];
        end
    endgenerate

    assign bus.out_valid = (state == DONE);
    assign bus.out_hash  = bus.out_valid ? folded : '0;
    assign bus.out_count = bus.out_valid ? cnt : '0;
    assign busy          = (state != IDLE);
endmodule

// File: doc/fnv1a_hash_core.md
FNV1A_HASH_CORE -- requirements
Module: fnv1a_hash_core

Interface
REQ-001 SHALL provide parameter HASH_W, default 32, hash state width; legal values 32 or 64 only.
REQ-002 SHALL provide parameter OUT_W, default HASH_W, output width; legal values HASH_W or HASH_W/2 (XOR-fold).
REQ-003 SHALL provide parameter CNT_W, default 16, width of the message byte counter.
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 mode  in  1  0 = FNV-1a (xor then multiply), 1 = FNV-1 (multiply then xor); sampled on the first byte of each message.
REQ-008 abort  in  1  discards the current message and returns to IDLE.
REQ-009 in_valid  in  1  byte offered.
REQ-010 in_data  in  8  message byte.
REQ-011 in_last  in  1  marks final byte of message.
REQ-012 in_ready  out  1  core accepts byte this cycle.
REQ-013 out_valid  out  1  result held.
REQ-014 out_ready  in  1  consumer accepts result.
REQ-015 out_hash  out  OUT_W  final (optionally folded) hash.
REQ-016 out_count  out  CNT_W  bytes in message, saturating.
REQ-017 busy  out  1  high in HASH or DONE state.

Function
REQ-018 Constants SHALL be: HASH_W=32 offset 0x811C9DC5, prime 0x01000193; HASH_W=64 offset 0xCBF29CE484222325, prime 0x00000100000001B3.
REQ-019 FSM SHALL have states IDLE, HASH, DONE; reset state IDLE.
REQ-020 A byte is accepted when in_valid && in_ready on a rising edge; in_ready = 1 in IDLE and HASH, 0 in DONE.
REQ-021 First accepted byte in IDLE SHALL seed state from the offset basis, latch mode, set count to 1, and go to HASH (or DONE if in_last).
REQ-022 Each accepted byte SHALL update state in one cycle: FNV-1a h = (h ^ byte) * prime; FNV-1 h = (h * prime) ^ byte; products truncated modulo 2^HASH_W.
REQ-023 Throughput SHALL be one byte per cycle with no bubbles; in_ready SHALL NOT depend combinationally on in_valid.
REQ-024 Accepting a byte with in_last SHALL move to DONE; out_valid asserts the cycle after acceptance (latency 1).
REQ-025 When OUT_W = HASH_W, out_hash = h; when OUT_W = HASH_W/2, out_hash = h[HASH_W-1:OUT_W] ^ h[OUT_W-1:0].
REQ-026 out_hash and out_count SHALL stay stable while out_valid && !out_ready.
REQ-027 out_valid && out_ready SHALL return to IDLE next cycle; a new message cannot be accepted in the same cycle as the handshake.
REQ-028 out_count SHALL increment per accepted byte and saturate at 2^CNT_W-1 without wrapping; the hash SHALL continue updating past saturation.
REQ-029 mode changes mid-message SHALL be ignored until the next message.
REQ-030 abort SHALL take priority over byte acceptance and output handshake in any state: next cycle IDLE, out_valid 0, byte in that cycle discarded.
REQ-031 out_hash and out_count SHALL read 0 whenever out_valid = 0.

Reset
REQ-032 rst SHALL take priority over abort and all inputs.
REQ-033 After rst: state IDLE, out_valid 0, out_hash 0, out_count 0, busy 0, in_ready 1, latched mode 0.
REQ-034 rst asserted mid-message or in DONE SHALL discard all state; no out_valid SHALL follow.

Verification
REQ-035 HASH_W=32, mode 0, single byte 0x61 with in_last -> next cycle out_valid=1, out_hash=0xE40C292C, out_count=1.
REQ-036 HASH_W=32, mode 1, byte 0x61 last -> out_hash=0x050C5D7E; HASH_W=64, mode 0, byte 0x61 -> 0xAF63DC4C8601EC8C.
REQ-037 HASH_W=32, mode 0, "foobar" streamed back-to-back (6 cycles, in_ready held 1) -> out_hash=0xBF9CF968, out_count=6.
REQ-038 HASH_W=32, OUT_W=16, byte 0x61 -> out_hash=0xCD20; hold out_ready=0 for 5 cycles -> value, in_ready=0 stable; out_ready=1 -> IDLE.
REQ-039 CNT_W=2, 5-byte message -> out_count=3 (saturated), hash equals full 5-byte reference value.
REQ-040 abort on byte 3 of "foobar", then rst mid-message of a second message -> no out_valid; a following "a" yields 0xE40C292C.
